// File: rtl/reg_file_hz.sv
// Two-read/one-write register file with a hazard scoreboard over in-flight destinations
// and an optional same-cycle write-to-read bypass.
module reg_file_hz #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned HAZ_DEPTH = 3,
    parameter int unsigned ZERO_REG  = 1,
    parameter int unsigned BYPASS_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    input  logic              RegWE,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              collision_valid,
    input  logic [ADDR_W-1:0] collision_addr,
    input  logic              flush,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [1:0]        pause
);

    localparam int unsigned NumRegs = 1 << ADDR_W;
    // With bypass the oldest entry writes back in the same cycle it would be checked.
    localparam int unsigned NumChk  = (BYPASS_EN != 0) ? HAZ_DEPTH - 1 : HAZ_DEPTH;

    logic [DATA_W-1:0]    r_mem [NumRegs];
    logic [HAZ_DEPTH-1:0] r_win_valid;
    logic [ADDR_W-1:0]    r_win_addr [HAZ_DEPTH];

    logic w_wr_ok;
    logic w_haz_rs;
    logic w_haz_rt;

    assign w_wr_ok = RegWE && !((ZERO_REG != 0) && (write_addr == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[write_addr] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_valid <= '0;
            for (int unsigned k = 0; k < HAZ_DEPTH; k++) begin
                r_win_addr[k] <= '0;
            end
        end else begin
            r_win_valid[0] <= collision_valid && !flush;
            r_win_addr[0]  <= collision_addr;
            for (int unsigned k = 1; k < HAZ_DEPTH; k++) begin
                r_win_valid[k] <= r_win_valid[k-1] && !flush;
                r_win_addr[k]  <= r_win_addr[k-1];
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] stored);
        if ((ZERO_REG != 0) && (addr == '0)) begin
            return '0;
        end else if ((BYPASS_EN != 0) && w_wr_ok && (write_addr == addr)) begin
            return write_data;
        end
        return stored;
    endfunction

    assign read_data1 = read_port(read_addr1, r_mem[read_addr1]);
    assign read_data2 = read_port(read_addr2, r_mem[read_addr2]);

    always_comb begin
        w_haz_rs = 1'b0;
        w_haz_rt = 1'b0;
        for (int unsigned k = 0; k < HAZ_DEPTH; k++) begin
            if ((k < NumChk) && r_win_valid[k]) begin
                if (r_win_addr[k] == read_addr1) w_haz_rs = 1'b1;
                if (r_win_addr[k] == read_addr2) w_haz_rt = 1'b1;
            end
        end
        if ((ZERO_REG != 0) && (read_addr1 == '0)) w_haz_rs = 1'b0;
        if ((ZERO_REG != 0) && (read_addr2 == '0)) w_haz_rt = 1'b0;
    end

    assign pause = {w_haz_rt, w_haz_rs};

endmodule
